// File: rtl/button_event_pkg.sv
// Shared types and default constants for the stopwatch button event decoder.
package button_event_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } btn_state_t;

  localparam int unsigned LONG_MS_DEF    = 500;
  localparam int unsigned REPEAT_MS_DEF  = 100;
  localparam int unsigned CLK_PER_MS_DEF = 100000;

  // Width of a counter that must be able to hold the value max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_event_chan.sv
// One button channel: edge detect, IDLE/HELD/LONG FSM, hold/repeat counters.
// Repeat logic exists only when BUTTON_EVENT_REPEAT_EN is defined.
module button_event_chan
  import button_event_pkg::*;
#(
  parameter int unsigned LONG_MS   = LONG_MS_DEF,
  parameter int unsigned REPEAT_MS = REPEAT_MS_DEF,
  parameter bit          REPEAT_ON = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam int unsigned          HOLD_W    = cnt_width(LONG_MS);
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(LONG_MS - 1);

  btn_state_t        state;
  logic              prev;
  logic [HOLD_W-1:0] hold_cnt;
  logic              rise;
  logic              fall;

  assign rise = btn & ~prev;
  assign fall = ~btn & prev;

`ifdef BUTTON_EVENT_REPEAT_EN
  localparam int unsigned       REP_W    = cnt_width(REPEAT_MS);
  localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REPEAT_MS - 1);

  logic [REP_W-1:0] rep_cnt;
`else
  // Repeat is compiled out; its configuration cannot change the output.
  assign repeat_pulse = 1'b0 & REPEAT_ON & (REPEAT_MS != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      prev          <= 1'b0;
      hold_cnt      <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      held          <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
      rep_cnt       <= '0;
      repeat_pulse  <= 1'b0;
`endif
    end else begin
      prev          <= btn;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
      repeat_pulse  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rise) begin
            state       <= HELD;
            hold_cnt    <= '0;
            press_pulse <= 1'b1;
            held        <= 1'b1;
          end
        end

        // A release always beats a tick landing in the same cycle.
        HELD: begin
          if (fall) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            release_pulse <= 1'b1;
            held          <= 1'b0;
          end else if (tick) begin
            hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == HOLD_LAST) begin
              state      <= LONG;
              long_pulse <= 1'b1;
`ifdef BUTTON_EVENT_REPEAT_EN
              rep_cnt    <= '0;
`endif
            end
          end
        end

        LONG: begin
          if (fall) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            release_pulse <= 1'b1;
            held          <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
            rep_cnt       <= '0;
          end else if (tick) begin
            if (rep_cnt == REP_LAST) begin
              rep_cnt      <= '0;
              repeat_pulse <= REPEAT_ON;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
`endif
          end
        end

        default: begin
          state <= IDLE;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_event.sv
// Button event decoder top: 1 ms tick prescaler plus N_BTN independent channels.
// Define BUTTON_EVENT_REPEAT_EN to build the hold-to-repeat logic.
module button_event
  import button_event_pkg::*;
#(
  parameter int unsigned           N_BTN       = 5,
  parameter int unsigned           CLK_PER_MS  = CLK_PER_MS_DEF,
  parameter int unsigned           LONG_MS     = LONG_MS_DEF,
  parameter int unsigned           REPEAT_MS   = REPEAT_MS_DEF,
  parameter logic [N_BTN-1:0]      REPEAT_MASK = 5'b11000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_db,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] repeat_pulse,
  output logic [N_BTN-1:0] held
);

  localparam int unsigned       PRE_W    = cnt_width(CLK_PER_MS - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_PER_MS - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;

  // tick is the prescaler wrap cycle, shared by every channel.
  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    button_event_chan #(
      .LONG_MS   (LONG_MS),
      .REPEAT_MS (REPEAT_MS),
      .REPEAT_ON (REPEAT_MASK[i])
    ) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .tick          (tick),
      .btn           (btn_db[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i]),
      .repeat_pulse  (repeat_pulse[i]),
      .held          (held[i])
    );
  end

endmodule

// File: tb/tb_button_event.sv
// Self-checking bench for button_event against a tick-counting reference model.
`timescale 1ns/1ps
module tb_button_event;

  localparam int N = 5;
  localparam int C = 10;
  localparam int L = 5;
  localparam int R = 2;
  localparam logic [N-1:0] MASK = 5'b11000;
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] btn_db = '0;
  logic [N-1:0] press_pulse, release_pulse, long_pulse, repeat_pulse, held;

  button_event #(
    .N_BTN       (N),
    .CLK_PER_MS  (C),
    .LONG_MS     (L),
    .REPEAT_MS   (R),
    .REPEAT_MASK (MASK)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_db        (btn_db),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .held          (held)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: counts ticks elapsed since the press, events follow from the count.
  logic [N-1:0] e_press, e_release, e_long, e_rep, e_held;
  int m_cyc;
  int m_ticks [N];
  bit m_act   [N];
  bit m_prev  [N];

  always @(posedge clk or negedge rst_n) begin : model
    bit tk;
    if (!rst_n) begin
      m_cyc = 0;
      e_press = '0; e_release = '0; e_long = '0; e_rep = '0; e_held = '0;
      for (int i = 0; i < N; i++) begin
        m_ticks[i] = 0; m_act[i] = 1'b0; m_prev[i] = 1'b0;
      end
    end else begin
      tk = ((m_cyc % C) == C - 1);
      m_cyc++;
      for (int i = 0; i < N; i++) begin
        e_press[i] = 1'b0; e_release[i] = 1'b0; e_long[i] = 1'b0; e_rep[i] = 1'b0;
        if (btn_db[i] && !m_prev[i]) begin
          m_act[i] = 1'b1; m_ticks[i] = 0; e_press[i] = 1'b1;
        end else if (!btn_db[i] && m_prev[i]) begin
          m_act[i] = 1'b0; m_ticks[i] = 0; e_release[i] = 1'b1;
        end else if (m_act[i] && tk) begin
          m_ticks[i]++;
          if (m_ticks[i] == L)
            e_long[i] = 1'b1;
          else if (REP_EN && MASK[i] && m_ticks[i] > L && ((m_ticks[i] - L) % R) == 0)
            e_rep[i] = 1'b1;
        end
        e_held[i] = m_act[i];
        m_prev[i] = btn_db[i];
      end
    end
  end

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({press_pulse, release_pulse, long_pulse, repeat_pulse, held} !== 25'd0) begin
      errors++;
      $display("FAIL reset_async got %b required 0", {press_pulse, release_pulse, long_pulse, repeat_pulse, held});
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({press_pulse, release_pulse, long_pulse, repeat_pulse, held} !== 25'd0) begin
        errors++;
        $display("FAIL reset_hold got %b required 0", {press_pulse, release_pulse, long_pulse, repeat_pulse, held});
      end
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({press_pulse, release_pulse, long_pulse, repeat_pulse, held} !== {e_press, e_release, e_long, e_rep, e_held}) begin
        errors++;
        $display("FAIL reset_idle t=%0t got %b exp %b", $time, {press_pulse, release_pulse, long_pulse, repeat_pulse, held}, {e_press, e_release, e_long, e_rep, e_held});
      end
    end
  endtask

  task automatic test_short_press();
    int s, press_k, rel_k, n_long;
    s = $urandom_range(1, 10); press_k = -1; rel_k = -1; n_long = 0;
    for (int k = 0; k < s + 35; k++) begin
      @(negedge clk);
      checks++;
      if ({press_pulse, release_pulse, long_pulse, repeat_pulse, held} !== {e_press, e_release, e_long, e_rep, e_held}) begin
        errors++;
        $display("FAIL short_press t=%0t got %b exp %b", $time, {press_pulse, release_pulse, long_pulse, repeat_pulse, held}, {e_press, e_release, e_long, e_rep, e_held});
      end
      if (press_pulse[1]) press_k = k;
      if (release_pulse[1]) rel_k = k;
      if (long_pulse[1]) n_long++;
      btn_db[1] = (k >= s && k < s + 20);
    end
    checks++;
    if (press_k != s + 1) begin
      errors++; $display("FAIL short_press_lat got %0d required %0d", press_k, s + 1);
    end
    checks++;
    if (rel_k != s + 21) begin
      errors++; $display("FAIL short_release_lat got %0d required %0d", rel_k, s + 21);
    end
    checks++;
    if (n_long != 0) begin
      errors++; $display("FAIL short_no_long got %0d required 0", n_long);
    end
  endtask

  task automatic test_long_repeat();
    int s, press_k, long_k, n_long, n_rel, ref_k;
    int rep_k[$];
    s = $urandom_range(1, 10); press_k = -1; long_k = -1; n_long = 0; n_rel = 0;
    for (int k = 0; k < s + 150; k++) begin
      @(negedge clk);
      checks++;
      if ({press_pulse, release_pulse, long_pulse, repeat_pulse, held} !== {e_press, e_release, e_long, e_rep, e_held}) begin
        errors++;
        $display("FAIL long_repeat t=%0t got %b exp %b", $time, {press_pulse, release_pulse, long_pulse, repeat_pulse, held}, {e_press, e_release, e_long, e_rep, e_held});
      end
      if (press_pulse[3]) press_k = k;
      if (long_pulse[3]) begin n_long++; long_k = k; end
      if (repeat_pulse[3]) rep_k.push_back(k);
      if (release_pulse[3]) n_rel++;
      btn_db[3] = (k >= s && k < s + 120);
    end
    checks++;
    if (n_long != 1) begin
      errors++; $display("FAIL long_count got %0d required 1", n_long);
    end
    checks++;
    if (long_k - press_k < (L - 1) * C + 1 || long_k - press_k > L * C) begin
      errors++; $display("FAIL long_latency got %0d required %0d..%0d", long_k - press_k, (L - 1) * C + 1, L * C);
    end
    checks++;
    if (rep_k.size() != (REP_EN ? 3 : 0)) begin
      errors++; $display("FAIL repeat_count got %0d required %0d", rep_k.size(), REP_EN ? 3 : 0);
    end
    for (int j = 0; j < rep_k.size(); j++) begin
      ref_k = (j == 0) ? long_k : rep_k[j - 1];
      checks++;
      if (rep_k[j] - ref_k != R * C) begin
        errors++; $display("FAIL repeat_spacing got %0d required %0d", rep_k[j] - ref_k, R * C);
      end
    end
    checks++;
    if (n_rel != 1) begin
      errors++; $display("FAIL long_release got %0d required 1", n_rel);
    end
  endtask

  task automatic test_masked();
    int s, n_long, n_rep;
    s = $urandom_range(1, 10); n_long = 0; n_rep = 0;
    for (int k = 0; k < s + 140; k++) begin
      @(negedge clk);
      checks++;
      if ({press_pulse, release_pulse, long_pulse, repeat_pulse, held} !== {e_press, e_release, e_long, e_rep, e_held}) begin
        errors++;
        $display("FAIL masked t=%0t got %b exp %b", $time, {press_pulse, release_pulse, long_pulse, repeat_pulse, held}, {e_press, e_release, e_long, e_rep, e_held});
      end
      if (long_pulse[0]) n_long++;
      if (repeat_pulse[0]) n_rep++;
      btn_db[0] = (k >= s && k < s + 120);
    end
    checks++;
    if (n_long != 1) begin
      errors++; $display("FAIL masked_long got %0d required 1", n_long);
    end
    checks++;
    if (n_rep != 0) begin
      errors++; $display("FAIL masked_repeat got %0d required 0", n_rep);
    end
  endtask

  task automatic test_release_at_threshold();
    bit dropped;
    int n_long, n_rel;
    dropped = 1'b0; n_long = 0; n_rel = 0;
    btn_db[3] = 1'b1;
    for (int k = 0; k < 90; k++) begin
      @(negedge clk);
      checks++;
      if ({press_pulse, release_pulse, long_pulse, repeat_pulse, held} !== {e_press, e_release, e_long, e_rep, e_held}) begin
        errors++;
        $display("FAIL rel_threshold t=%0t got %b exp %b", $time, {press_pulse, release_pulse, long_pulse, repeat_pulse, held}, {e_press, e_release, e_long, e_rep, e_held});
      end
      if (long_pulse[3]) n_long++;
      if (release_pulse[3]) n_rel++;
      if (!dropped && m_act[3] && m_ticks[3] == L - 1 && (m_cyc % C) == C - 1) begin
        btn_db[3] = 1'b0;
        dropped = 1'b1;
      end
    end
    btn_db[3] = 1'b0;
    checks++;
    if (!dropped) begin
      errors++; $display("FAIL rel_threshold_timeout got 0 required 1");
    end
    checks++;
    if (n_long != 0) begin
      errors++; $display("FAIL rel_threshold_long got %0d required 0", n_long);
    end
    checks++;
    if (n_rel != 1) begin
      errors++; $display("FAIL rel_threshold_release got %0d required 1", n_rel);
    end
  endtask

  task automatic test_back_to_back();
    int s, press_k, rel_k, n_long;
    s = $urandom_range(1, 10); press_k = -1; rel_k = -1; n_long = 0;
    for (int k = 0; k < s + 70; k++) begin
      @(negedge clk);
      checks++;
      if ({press_pulse, release_pulse, long_pulse, repeat_pulse, held} !== {e_press, e_release, e_long, e_rep, e_held}) begin
        errors++;
        $display("FAIL glitch t=%0t got %b exp %b", $time, {press_pulse, release_pulse, long_pulse, repeat_pulse, held}, {e_press, e_release, e_long, e_rep, e_held});
      end
      if (press_pulse[2]) press_k = k;
      if (release_pulse[2]) rel_k = k;
      if (long_pulse[2]) n_long++;
      btn_db[2] = (k == s);
    end
    checks++;
    if (press_k != s + 1 || rel_k != s + 2) begin
      errors++; $display("FAIL glitch_pulses got %0d,%0d required %0d,%0d", press_k, rel_k, s + 1, s + 2);
    end
    checks++;
    if (n_long != 0) begin
      errors++; $display("FAIL glitch_long got %0d required 0", n_long);
    end
  endtask

  task automatic test_reset_mid_hold();
    bit got_long;
    int extra;
    got_long = 1'b0; extra = $urandom_range(1, 15);
    btn_db[4] = 1'b1;
    for (int k = 0; k < 80 && !got_long; k++) begin
      @(negedge clk);
      checks++;
      if ({press_pulse, release_pulse, long_pulse, repeat_pulse, held} !== {e_press, e_release, e_long, e_rep, e_held}) begin
        errors++;
        $display("FAIL mid_reset_hold t=%0t got %b exp %b", $time, {press_pulse, release_pulse, long_pulse, repeat_pulse, held}, {e_press, e_release, e_long, e_rep, e_held});
      end
      if (long_pulse[4]) got_long = 1'b1;
    end
    checks++;
    if (!got_long) begin
      errors++; $display("FAIL mid_reset_long_timeout got 0 required 1");
    end
    repeat (extra) begin
      @(negedge clk);
      checks++;
      if ({press_pulse, release_pulse, long_pulse, repeat_pulse, held} !== {e_press, e_release, e_long, e_rep, e_held}) begin
        errors++;
        $display("FAIL mid_reset_long t=%0t got %b exp %b", $time, {press_pulse, release_pulse, long_pulse, repeat_pulse, held}, {e_press, e_release, e_long, e_rep, e_held});
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({press_pulse, release_pulse, long_pulse, repeat_pulse, held} !== 25'd0) begin
      errors++;
      $display("FAIL mid_reset_async got %b required 0", {press_pulse, release_pulse, long_pulse, repeat_pulse, held});
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({press_pulse, release_pulse, long_pulse, repeat_pulse, held} !== 25'd0) begin
        errors++;
        $display("FAIL mid_reset_quiet got %b required 0", {press_pulse, release_pulse, long_pulse, repeat_pulse, held});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (press_pulse[4] !== 1'b1 || held[4] !== 1'b1) begin
      errors++; $display("FAIL mid_reset_repress got %b%b required 11", press_pulse[4], held[4]);
    end
    for (int k = 0; k < 12; k++) begin
      if (k == 6) btn_db[4] = 1'b0;
      @(negedge clk);
      checks++;
      if ({press_pulse, release_pulse, long_pulse, repeat_pulse, held} !== {e_press, e_release, e_long, e_rep, e_held}) begin
        errors++;
        $display("FAIL mid_reset_after t=%0t got %b exp %b", $time, {press_pulse, release_pulse, long_pulse, repeat_pulse, held}, {e_press, e_release, e_long, e_rep, e_held});
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 2500; k++) begin
      @(negedge clk);
      checks++;
      if ({press_pulse, release_pulse, long_pulse, repeat_pulse, held} !== {e_press, e_release, e_long, e_rep, e_held}) begin
        errors++;
        $display("FAIL random t=%0t got %b exp %b", $time, {press_pulse, release_pulse, long_pulse, repeat_pulse, held}, {e_press, e_release, e_long, e_rep, e_held});
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 39) == 0) btn_db[i] = ~btn_db[i];
      end
    end
    btn_db = '0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({press_pulse, release_pulse, long_pulse, repeat_pulse, held} !== {e_press, e_release, e_long, e_rep, e_held}) begin
        errors++;
        $display("FAIL random_drain t=%0t got %b exp %b", $time, {press_pulse, release_pulse, long_pulse, repeat_pulse, held}, {e_press, e_release, e_long, e_rep, e_held});
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_repeat();
    test_masked();
    test_release_at_threshold();
    test_back_to_back();
    test_reset_mid_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
